// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared mcause codes, FSM encoding, size one-hot ordering
// and store lane helpers for the memory access stage.
package mem_access_stage_pkg;

    localparam logic [31:0] CAUSE_LD_MISALIGN = 32'd4;
    localparam logic [31:0] CAUSE_LD_FAULT    = 32'd5;
    localparam logic [31:0] CAUSE_ST_MISALIGN = 32'd6;
    localparam logic [31:0] CAUSE_ST_FAULT    = 32'd7;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Access size is carried as a one-hot {w, h, b}
    localparam int SZ_B = 0;
    localparam int SZ_H = 1;
    localparam int SZ_W = 2;

    typedef logic [2:0] size_t;

    function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] off);
        return sz[SZ_B] ? 4'b0001 << off : sz[SZ_H] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] sd);
        return sz[SZ_B] ? {4{sd[7:0]}} : sz[SZ_H] ? {2{sd[15:0]}} : sd;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// mem_access_stage_load_align: picks the addressed byte/half out of the read
// word and sign- or zero-extends it; words pass straight through.
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  size_t       sz_i,
    input  logic        bhu_i,
    output logic [31:0] data_o
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    assign bsel   = rdata_i[8*off_i +: 8];
    assign hsel   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign data_o = sz_i[SZ_B] ? {{24{~bhu_i & bsel[7]}}, bsel}
                  : sz_i[SZ_H] ? {{16{~bhu_i & hsel[15]}}, hsel}
                  : rdata_i;

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: drives load/store transactions on the req/ack data port,
// raises misalign/timeout traps and owns the MEM/WB pipeline register.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bhu,
    input  logic        b,
    input  logic        h,
    input  logic        w,
    input  logic        wb_src,
    input  logic        reg_write,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] pc,
    input  logic [31:0] store_data,
    input  logic [31:0] alu_out,
    input  logic [4:0]  rd,
    input  logic        flush,
    input  logic        mem_wb_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        trap_req,
    output logic [31:0] trap_cause,
    output logic [31:0] trap_val,
    output logic [31:0] trap_pc,
    output logic        wb_src_reg,
    output logic        reg_write_reg,
    output logic [31:0] alu_out_reg,
    output logic [31:0] load_data_reg,
    output logic [31:0] pc_reg,
    output logic [4:0]  rd_reg
);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        drop_q, drop_d;
    logic        we_q, bhu_q;
    logic [31:0] ea_q, wdata_q, pc_q;
    logic [3:0]  be_q;
    size_t       sz_q;
    logic        wb_src_q, reg_write_q;
    logic [31:0] alu_out_q, load_data_q, pc_wb_q;
    logic [4:0]  rd_q;

    size_t       sz;
    logic        idle, access, misaligned, timeout, ack, done, wb_clr, wb_en;
    logic [31:0] ea, ld_ext;

    assign sz         = {w, h, b};
    assign idle       = state_q == ST_IDLE;
    assign access     = mem_read | mem_write;
    assign misaligned = (h & alu_out[0]) | (w & |alu_out[1:0]);
    assign timeout    = ~idle & (cnt_q == 8'(TIMEOUT));
    assign ack        = dmem_ack & dmem_req;
    assign done       = ~idle & (ack | timeout);
    assign ea         = idle ? alu_out : ea_q;

    // Reset gates the combinational outputs so they read 0 while rst is low
    assign dmem_req   = rst & (idle ? access & ~misaligned & ~flush : ~timeout);
    assign dmem_we    = idle ? mem_write : we_q;
    assign dmem_addr  = {ea[31:2], 2'b00};
    assign dmem_wdata = idle ? store_wdata(sz, store_data) : wdata_q;
    assign dmem_be    = idle ? (mem_write ? store_be(sz, alu_out[1:0]) : 4'hF) : be_q;
    assign mem_stall  = dmem_req & ~dmem_ack;

    assign trap_req   = rst & ~flush & ((idle & access & misaligned) | (timeout & ~drop_q));
    assign trap_cause = idle ? (mem_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN)
                             : (we_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT);
    assign trap_val   = ea;
    assign trap_pc    = idle ? pc : pc_q;

    assign state_d = idle ? (mem_stall ? ST_BUSY : ST_IDLE) : (done ? ST_IDLE : ST_BUSY);
    assign cnt_d   = idle ? (mem_stall ? 8'd1 : 8'd0) : (done ? 8'd0 : cnt_q + 8'd1);
    assign drop_d  = ~idle & ~done & (drop_q | flush);
    assign wb_clr  = flush | trap_req | (done & drop_q);
    assign wb_en   = mem_wb_en & ~mem_stall;

    mem_access_stage_load_align u_align (
        .rdata_i (dmem_rdata),
        .off_i   (ea[1:0]),
        .sz_i    (idle ? sz : sz_q),
        .bhu_i   (idle ? bhu : bhu_q),
        .data_o  (ld_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            we_q    <= 1'b0;
            bhu_q   <= 1'b0;
            ea_q    <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            be_q    <= '0;
            sz_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            // Freeze the bus-side view while a transaction is outstanding
            if (idle) begin
                we_q    <= mem_write;
                bhu_q   <= bhu;
                ea_q    <= alu_out;
                wdata_q <= dmem_wdata;
                pc_q    <= pc;
                be_q    <= dmem_be;
                sz_q    <= sz;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            alu_out_q   <= '0;
            load_data_q <= '0;
            pc_wb_q     <= '0;
            rd_q        <= '0;
        end else if (wb_clr) begin
            wb_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            alu_out_q   <= '0;
            load_data_q <= '0;
            pc_wb_q     <= '0;
            rd_q        <= '0;
        end else if (wb_en) begin
            wb_src_q    <= wb_src;
            reg_write_q <= reg_write;
            alu_out_q   <= alu_out;
            pc_wb_q     <= pc;
            rd_q        <= rd;
            if (ack) load_data_q <= ld_ext;
        end
    end

    assign wb_src_reg    = wb_src_q;
    assign reg_write_reg = reg_write_q;
    assign alu_out_reg   = alu_out_q;
    assign load_data_reg = load_data_q;
    assign pc_reg        = pc_wb_q;
    assign rd_reg        = rd_q;

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register contents and runs load/store transactions on a req/ack data-memory port.
- Aligns, sign- or zero-extends load data; detects misaligned and timed-out accesses and raises a trap request with mcause/mtval.
- Stalls the pipeline while a transaction is outstanding and owns the MEM/WB pipeline register.

Parameters:
- TIMEOUT, 255, BUSY cycles without dmem_ack before the access is aborted as an access fault (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- bhu, b, h, w  in  1 each  access size (byte/half/word); bhu=1 selects zero-extension on loads
- wb_src  in  1  writeback source (0: ALU result, 1: load data)
- reg_write  in  1  register write enable
- mem_read, mem_write  in  1 each  load/store request
- pc  in  32  instruction PC
- store_data  in  32  rs2 value
- alu_out  in  32  effective address or ALU result
- rd  in  5  destination register
- flush  in  1  trap/mret flush
- mem_wb_en  in  1  MEM/WB load enable from hazard unit
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word-aligned address ({alu_out[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  transaction done; rdata valid this cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  to hazard unit
- trap_req  out  1  one-cycle exception pulse
- trap_cause  out  32  mcause value
- trap_val  out  32  mtval (faulting address)
- trap_pc  out  32  faulting PC (mepc source)
- wb_src_reg, reg_write_reg  out  1 each  MEM/WB outputs
- alu_out_reg, load_data_reg, pc_reg  out  32 each  MEM/WB outputs
- rd_reg  out  5  MEM/WB output

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE, timeout counter 0, drop flag 0.
  - All registered outputs 0.
  - dmem_req=0, mem_stall=0, trap_req=0.
- access = mem_read|mem_write.
- misaligned = (h & alu_out[0]) | (w & |alu_out[1:0]).
- FSM states:
  - IDLE: dmem_req = access & ~misaligned & ~flush (combinational, same cycle). If dmem_ack is also 1: zero-latency completion, no stall. If req without ack: go to BUSY, counter=1.
  - BUSY: dmem_req held at 1; dmem_we/addr/wdata/be held from captured copies, independent of upstream changes. Counter increments each cycle. On ack: go to IDLE. When counter reaches TIMEOUT without ack: go to IDLE, drop req, raise timeout fault.
- mem_stall = dmem_req & ~dmem_ack.
- Stores:
  - b: be = 1<<addr[1:0]; wdata = {4{sd[7:0]}}.
  - h: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{sd[15:0]}}.
  - w: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Loads: select byte by addr[1:0] or half by addr[1] from dmem_rdata; extend per bhu; word passes through.
- Exceptions (one-cycle trap_req; trap_val=alu_out; trap_pc=pc):
  - misaligned load: cause 4; misaligned store: cause 6. No bus request is issued.
  - timeout load: cause 5; timeout store: cause 7.
  - Flush has priority: no trap is raised if flush=1 that cycle.
- Flush while BUSY:
  - The bus transaction is never abandoned; req is held until ack or timeout.
  - drop=1 is set; the completion is discarded with no writeback and no trap.
  - drop clears on return to IDLE.
- MEM/WB register:
  - Loads when mem_wb_en & ~mem_stall.
  - Synchronous clear to 0 when flush, when an exception fires, or when a dropped access completes.
  - load_data_reg captures extended data on the ack cycle.
- Non-memory instructions pass through to MEM/WB in one cycle; no stall.

Decomposition:
- Shared package holds:
  - mcause constants (4, 5, 6, 7)
  - FSM state encoding (IDLE=0, BUSY=1)
  - size-select one-hot ordering
- One sub-module is natural: load_align (combinational rdata select and extend, 32-bit in, 32-bit out).

Test Plan:
- lb, addr 0x1003, rdata 0x80AA_BBCC, ack same cycle, bhu=0 → no stall; load_data_reg=0xFFFF_FF80 next cycle.
- sh, addr 0x2002, sd=0x1234_5678 → be=1100, wdata=0x5678_5678, addr=0x2000; ack after 3 cycles → mem_stall high exactly 3 cycles.
- lw, addr 0x3001 → dmem_req=0; trap_req 1 cycle with cause 4, trap_val 0x3001; reg_write_reg=0.
- sw, never acked, TIMEOUT=4 → stall 4 cycles; then trap cause 7 and dmem_req drops.
- lhu in BUSY, flush asserted, ack 2 cycles later → no trap; MEM/WB reg_write_reg=0; FSM back to IDLE.
- Reset asserted mid-BUSY → dmem_req and all outputs 0 immediately (async); FSM in IDLE.
